// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter that time-shares one single-port synchronous RAM between
// a processor data port (requester 0) and a display scan port (requester 1).
module ram_port_arbiter #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 12
) (
    input  logic                     clk,
    input  logic                     reset_n,

    input  logic                     req0_valid,
    output logic                     req0_ready,
    input  logic                     req0_we,
    input  logic [ADDRESS_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0]    req0_wdata,
    output logic                     rsp0_valid,
    output logic [DATA_WIDTH-1:0]    rsp0_rdata,

    input  logic                     req1_valid,
    output logic                     req1_ready,
    input  logic                     req1_we,
    input  logic [ADDRESS_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0]    req1_wdata,
    output logic                     rsp1_valid,
    output logic [DATA_WIDTH-1:0]    rsp1_rdata,

    output logic                     ram_wEn,
    output logic [ADDRESS_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0]    ram_dataIn,
    input  logic [DATA_WIDTH-1:0]    ram_dataOut
);

    logic w_gnt0;
    logic w_gnt1;
    logic w_rsp0;
    logic w_rsp1;

    logic r_last_grant;   // index of the most recently accepted requester
    logic r_pend_valid;   // a read was accepted on the previous edge
    logic r_pend_idx;     // which requester that read belongs to

    // On a tie the requester that did not win last time is granted.
    always_comb begin
        w_gnt0 = reset_n && req0_valid && (!req1_valid || r_last_grant);
        w_gnt1 = reset_n && req1_valid && (!req0_valid || !r_last_grant);
    end

    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        ram_wEn    = 1'b0;
        ram_addr   = '0;
        ram_dataIn = '0;
        if (w_gnt0) begin
            ram_wEn    = req0_we;
            ram_addr   = req0_addr;
            ram_dataIn = req0_wdata;
        end else if (w_gnt1) begin
            ram_wEn    = req1_we;
            ram_addr   = req1_addr;
            ram_dataIn = req1_wdata;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments; reset is sampled on the clock edge.
        if (!reset_n) begin
            r_last_grant <= 1'b1;
            r_pend_valid <= 1'b0;
            r_pend_idx   <= 1'b0;
        end else begin
            r_pend_valid <= (w_gnt0 && !req0_we) || (w_gnt1 && !req1_we);
            r_pend_idx   <= w_gnt1;
            if (w_gnt0 || w_gnt1) begin
                r_last_grant <= w_gnt1;
            end
        end
    end

    // Gating with reset_n drops a read that was in flight when reset arrived.
    assign w_rsp0 = reset_n && r_pend_valid && !r_pend_idx;
    assign w_rsp1 = reset_n && r_pend_valid &&  r_pend_idx;

    assign rsp0_valid = w_rsp0;
    assign rsp1_valid = w_rsp1;
    assign rsp0_rdata = w_rsp0 ? ram_dataOut : '0;
    assign rsp1_rdata = w_rsp1 ? ram_dataOut : '0;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter: directed stimulus pushes expected read
// responses into per-requester queues; a monitor pops and compares them.
module tb_ram_port_arbiter;

    localparam int DW = 32;
    localparam int AW = 12;

    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } exp_t;

    logic          clk;
    logic          reset_n;
    logic          req0_valid, req0_ready, req0_we;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_wdata;
    logic          rsp0_valid;
    logic [DW-1:0] rsp0_rdata;
    logic          req1_valid, req1_ready, req1_we;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_wdata;
    logic          rsp1_valid;
    logic [DW-1:0] rsp1_rdata;
    logic          ram_wEn;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_dataIn;
    logic [DW-1:0] ram_dataOut;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    bit   mon_en = 1'b0;
    exp_t q0[$];
    exp_t q1[$];

    logic [DW-1:0] ram     [0:(1<<AW)-1];
    bit            ram_wr  [0:(1<<AW)-1];
    logic [DW-1:0] exp_mem [0:(1<<AW)-1];

    ram_port_arbiter #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
        .ram_wEn(ram_wEn), .ram_addr(ram_addr), .ram_dataIn(ram_dataIn),
        .ram_dataOut(ram_dataOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        return 32'h5A00_0000 | {20'h0, a};
    endfunction

    // Single-port RAM: registered read, read suppressed on write cycles.
    always @(posedge clk) begin
        if (ram_wEn) begin
            ram[ram_addr]    <= ram_dataIn;
            ram_wr[ram_addr] <= 1'b1;
        end else begin
            ram_dataOut <= ram_wr[ram_addr] ? ram[ram_addr] : pat(ram_addr);
        end
    end

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (cycle %0d): got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Monitor: compares each response cycle against the queue heads.
    initial begin
        wait (mon_en);
        forever begin
            @(negedge clk);
            begin
                bit ev0, ev1;
                ev0 = (q0.size() > 0) && (q0[0].due == cyc);
                ev1 = (q1.size() > 0) && (q1[0].due == cyc);
                check("rsp0_valid", {31'b0, rsp0_valid}, {31'b0, ev0});
                check("rsp1_valid", {31'b0, rsp1_valid}, {31'b0, ev1});
                if (ev0) begin
                    check("rsp0_rdata", rsp0_rdata, q0[0].data);
                    void'(q0.pop_front());
                end else begin
                    check("rsp0_rdata_idle", rsp0_rdata, '0);
                end
                if (ev1) begin
                    check("rsp1_rdata", rsp1_rdata, q1[0].data);
                    void'(q1.pop_front());
                end else begin
                    check("rsp1_rdata_idle", rsp1_rdata, '0);
                end
            end
        end
    end

    task automatic drive(input logic rst_n,
                         input logic v0, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                         input logic v1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        @(posedge clk);
        #1;
        reset_n    = rst_n;
        req0_valid = v0; req0_we = w0; req0_addr = a0; req0_wdata = d0;
        req1_valid = v1; req1_we = w1; req1_addr = a1; req1_wdata = d1;
        if (!rst_n) begin
            q0.delete();
            q1.delete();
        end
    endtask

    task automatic idle();
        drive(1'b1, 1'b0, 1'b1, 12'hFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 12'hFFF, 32'hFFFF_FFFF);
    endtask

    // Checks grant/RAM drive for this cycle and records what should come back.
    task automatic sample(input string nm, input logic e0, input logic e1, input logic e_wen);
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_din;
        @(negedge clk);
        e_addr = e0 ? req0_addr  : (e1 ? req1_addr  : '0);
        e_din  = e0 ? req0_wdata : (e1 ? req1_wdata : '0);
        check({nm, ".req0_ready"}, {31'b0, req0_ready}, {31'b0, e0});
        check({nm, ".req1_ready"}, {31'b0, req1_ready}, {31'b0, e1});
        check({nm, ".ram_wEn"},    {31'b0, ram_wEn},    {31'b0, e_wen});
        check({nm, ".ram_addr"},   {20'b0, ram_addr},   {20'b0, e_addr});
        check({nm, ".ram_dataIn"}, ram_dataIn,          e_din);
        if (e0) begin
            if (req0_we) exp_mem[req0_addr] = req0_wdata;
            else         q0.push_back('{cyc + 1, exp_mem[req0_addr]});
        end
        if (e1) begin
            if (req1_we) exp_mem[req1_addr] = req1_wdata;
            else         q1.push_back('{cyc + 1, exp_mem[req1_addr]});
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n0, n1;
        for (int i = 0; i < (1 << AW); i++) exp_mem[i] = pat(i[AW-1:0]);
        reset_n = 1'b0;
        req0_valid = 1'b0; req0_we = 1'b0; req0_addr = '0; req0_wdata = '0;
        req1_valid = 1'b0; req1_we = 1'b0; req1_addr = '0; req1_wdata = '0;

        // Reset: requests and writes are ignored while reset_n is low.
        drive(1'b0, 1'b1, 1'b1, 12'h001, 32'h1111_1111, 1'b1, 1'b1, 12'h002, 32'h2222_2222);
        mon_en = 1'b1;
        sample("reset", 1'b0, 1'b0, 1'b0);

        // Tie after reset goes to requester 0; read data 0x5A000010 then 0x5A000020.
        drive(1'b1, 1'b1, 1'b0, 12'h010, '0, 1'b1, 1'b0, 12'h020, '0);
        sample("tie0", 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 12'h010, '0, 1'b1, 1'b0, 12'h020, '0);
        sample("tie1", 1'b0, 1'b1, 1'b0);

        // Both held valid: strict alternation starting with requester 0.
        n0 = 0;
        n1 = 0;
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 1'b1, 1'b0, 12'h030, '0, 1'b1, 1'b0, 12'h040, '0);
            sample("alt", (k % 2) == 0, (k % 2) == 1, 1'b0);
            n0 += int'(req0_ready);
            n1 += int'(req1_ready);
        end
        check("alt.count0", n0, 4);
        check("alt.count1", n1, 4);

        // Write then read the same address: new data comes back, write gets no response.
        drive(1'b1, 1'b1, 1'b1, 12'h005, 32'hDEAD_BEEF, 1'b0, 1'b0, 12'h000, '0);
        sample("wr", 1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 1'b0, 12'h005, '0, 1'b0, 1'b0, 12'h000, '0);
        sample("rd", 1'b1, 1'b0, 1'b0);
        check("wr.model", exp_mem[12'h005], 32'hDEAD_BEEF);

        // Requester 1 alone: five back-to-back reads of 0x100..0x104.
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 1'b0, 1'b0, 12'h000, '0, 1'b1, 1'b0, 12'h100 + 12'(k), '0);
            sample("burst1", 1'b0, 1'b1, 1'b0);
        end

        // Read accepted, then reset: the response is dropped and round-robin restarts.
        drive(1'b1, 1'b1, 1'b0, 12'h077, '0, 1'b0, 1'b0, 12'h000, '0);
        sample("pre_rst", 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 12'h077, 32'h0BAD_0BAD, 1'b1, 1'b1, 12'h078, 32'h0BAD_0BAD);
        sample("mid_rst0", 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 12'h077, 32'h0BAD_0BAD, 1'b1, 1'b1, 12'h078, 32'h0BAD_0BAD);
        sample("mid_rst1", 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 12'h011, '0, 1'b1, 1'b0, 12'h021, '0);
        sample("post_rst0", 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 12'h011, '0, 1'b1, 1'b0, 12'h021, '0);
        sample("post_rst1", 1'b0, 1'b1, 1'b0);

        // Idle: nothing granted, RAM driven to zero even with write-like inputs.
        for (int k = 0; k < 3; k++) begin
            idle();
            sample("idle", 1'b0, 1'b0, 1'b0);
        end

        check("rsp0_queue_drained", q0.size(), 0);
        check("rsp1_queue_drained", q1.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
